btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 13 +
 rtl/debounce_fsm.sv | 92 +++++++++
 rtl/btn_conditioner.sv | 55 +++++
 tb/tb_btn_conditioner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner and its debounce FSMs.
package btn_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } db_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

endpackage

// File: rtl/debounce_fsm.sv
// One button channel: 2-flop synchronizer, four-state debounce FSM with hold counter,
// registered debounced level and a one-cycle strobe on each committed rising edge.
module debounce_fsm
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("debounce_fsm: DEBOUNCE_CYCLES must be at least 2");
  end

  logic          sync_q1;
  logic          sync_q2;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Counter is cleared on every entry to and exit from a WAIT state, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (sync_q2) begin
            state <= WAIT_HI;
            cnt   <= '0;
          end
        end
        WAIT_HI: begin
          if (!sync_q2) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABLE_HI: begin
          if (!sync_q2) begin
            state <= WAIT_LO;
            cnt   <= '0;
          end
        end
        WAIT_LO: begin
          if (sync_q2) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            level <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Two-button conditioner: debounced levels, load strobe for the capture register, mux select.
// Build option: define BTN_TOGGLE_EN to make sel toggle per press of button 1 instead of momentary.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn_raw,
  output logic [1:0] btn_db,
  output logic       load_pulse,
  output logic       sel
);

  logic [1:0] rise;

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_raw[0]),
    .level (btn_db[0]),
    .rise  (rise[0])
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_raw[1]),
    .level (btn_db[1]),
    .rise  (rise[1])
  );

  assign load_pulse = rise[0];

`ifdef BTN_TOGGLE_EN
  logic sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
    end else if (rise[1]) begin
      sel_q <= ~sel_q;
    end
  end

  // rise[1] is a flop, so sel shows the new value in the same cycle btn_db[1] rises.
  assign sel = sel_q ^ rise[1];
`else
  logic unused_rise1;
  assign unused_rise1 = rise[1];
  assign sel          = btn_db[1];
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4 and a run-length reference model.
module tb_btn_conditioner;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] db;
    logic       lp;
    logic       sel;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_db;
  logic       load_pulse;
  logic       sel;

  btn_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_db     (btn_db),
    .load_pulse (load_pulse),
    .sel        (sel)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  obs_t sb[$];

  // Reference model: raw samples reach the FSM two edges late; a level flips once
  // N+1 consecutive seen samples differ from it.
  logic [1:0] p1 = '0, p2 = '0, lvl = '0;
  int         run[2] = '{0, 0};
  logic       tog = 1'b0;

  always @(posedge clk) begin
    obs_t       e;
    logic [1:0] seen;
    logic [1:0] pulse;
    cyc++;
    pulse = '0;
    if (!rst_n) begin
      p1 = '0; p2 = '0; lvl = '0; run[0] = 0; run[1] = 0; tog = 1'b0;
    end else begin
      seen = p2;
      p2 = p1;
      p1 = btn_raw;
      for (int b = 0; b < 2; b++) begin
        if (seen[b] != lvl[b]) begin
          run[b]++;
          if (run[b] == N + 1) begin
            lvl[b] = ~lvl[b];
            run[b] = 0;
            pulse[b] = lvl[b];
          end
        end else begin
          run[b] = 0;
        end
      end
      if (pulse[1]) tog = ~tog;
    end
    e.db = lvl;
    e.lp = pulse[0];
`ifdef BTN_TOGGLE_EN
    e.sel = tog;
`else
    e.sel = lvl[1];
`endif
    sb.push_back(e);
  end

  int   pulses = 0;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  logic prev_db0 = 1'b0;
  logic seen_sel = 1'b0;
  logic seen_db1 = 1'b0;

  always @(posedge clk) begin
    obs_t e;
    obs_t got;
    #1;
    got = {btn_db, load_pulse, sel};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty cyc=%0d got=%b exp=<none>", cyc, got);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL scoreboard cyc=%0d got db=%b lp=%b sel=%b exp db=%b lp=%b sel=%b",
                 cyc, got.db, got.lp, got.sel, e.db, e.lp, e.sel);
      end
    end
    if (load_pulse === 1'b1) pulses++;
    if (sel === 1'b1) seen_sel = 1'b1;
    if (btn_db[1] === 1'b1) seen_db1 = 1'b1;
    if (btn_db[0] === 1'b1 && !prev_db0) rise_cyc = cyc;
    if (btn_db[0] === 1'b0 && prev_db0) fall_cyc = cyc;
    prev_db0 = btn_db[0];
  end

  int drv_cyc = 0;

  task automatic drive(input logic [1:0] v);
    @(negedge clk);
    btn_raw = v;
    drv_cyc = cyc + 1;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int rel;
    int exp_sel;
    logic [1:0] r;

    rst_n   = 1'b0;
    btn_raw = 2'b11;
    hold(3);
    check("reset_db", int'(btn_db), 0);
    check("reset_lp", int'(load_pulse), 0);
    check("reset_sel", int'(sel), 0);

    pulses = 0; rise_cyc = -1;
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc + 1;
    hold(12);
    check("post_reset_latency", rise_cyc - rel, N + 2);
    check("post_reset_pulses", pulses, 1);
    drive(2'b00);
    hold(12);

    pulses = 0; rise_cyc = -1;
    drive(2'b01);
    hold(20);
    check("press_latency", rise_cyc - drv_cyc, N + 2);
    check("press_pulses", pulses, 1);
    fall_cyc = -1;
    drive(2'b00);
    hold(12);
    check("release_latency", fall_cyc - drv_cyc, N + 2);
    check("release_pulses", pulses, 1);

    pulses = 0; rise_cyc = -1;
    drive(2'b01); drive(2'b00); drive(2'b01); drive(2'b00);
    drive(2'b01);
    hold(15);
    check("bounce_latency", rise_cyc - drv_cyc, N + 2);
    check("bounce_pulses", pulses, 1);
    drive(2'b00);
    hold(12);

    seen_sel = 1'b0; seen_db1 = 1'b0;
    drive(2'b10);
    hold(2);
    drive(2'b00);
    hold(12);
    check("glitch_sel", int'(seen_sel), 0);
    check("glitch_db1", int'(seen_db1), 0);

    drive(2'b01);
    hold(2);
    rst_n = 1'b0;
    hold(2);
    check("midreset_db", int'(btn_db), 0);
    pulses = 0; rise_cyc = -1;
    rst_n = 1'b1;
    rel = cyc + 1;
    hold(12);
    check("midreset_latency", rise_cyc - rel, N + 2);
    check("midreset_pulses", pulses, 1);
    drive(2'b00);
    hold(12);

    for (int i = 0; i < 3; i++) begin
      drive(2'b10);
      hold(10);
`ifdef BTN_TOGGLE_EN
      exp_sel = (i % 2 == 0) ? 1 : 0;
`else
      exp_sel = 1;
`endif
      check("sel_pressed", int'(sel), exp_sel);
      drive(2'b00);
      hold(10);
`ifndef BTN_TOGGLE_EN
      exp_sel = 0;
`endif
      check("sel_released", int'(sel), exp_sel);
    end

    r = 2'b00;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      btn_raw = r;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end

    @(negedge clk);
    rst_n = 1'b1;
    btn_raw = 2'b00;
    hold(12);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
